// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data RAM slave with fixed read latency, stall and illegal-request flagging
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_rvalid,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [7:0]  err_count
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);
  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, word;
  logic [31:0]           din_q;
  logic [7:0]            errc_q, errc_d;
  logic [31:0]           ram_q [2**ADDR_WIDTH];
  logic                  in_idle, legal, rd_go, wr_go, err, load;
  assign word    = mem_addr[ADDR_WIDTH+1:2];
  assign in_idle = state_q == IDLE;
  assign legal   = mem_addr[1:0] == 2'b00 && (mem_addr >> (ADDR_WIDTH + 2)) == 32'd0 && !(mem_ren && mem_wen);
  assign rd_go   = in_idle && mem_ren && legal;
  assign wr_go   = in_idle && mem_wen && legal && mem_en;
  assign err     = in_idle && (mem_ren || mem_wen) && !legal;
  // RAM data is captured only on the edge that enters DONE
  assign load    = state_d == DONE && state_q != DONE;
  // state, latency counter, captured address and error counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      errc_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      errc_q  <= errc_d;
    end
  end
  // next-state: IDLE launches reads, WAIT counts down, DONE waits for the pipeline
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: if (rd_go) begin
        state_d = LATENCY > 1 ? WAIT : DONE;
        cnt_d   = CNT_INIT;
        addr_d  = word;
      end
      WAIT: begin
        cnt_d   = cnt_q - 3'd1;
        state_d = cnt_q == 3'd1 ? DONE : WAIT;
      end
      DONE:    state_d = mem_en ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // outputs: stall and err are combinational in IDLE, the rest come from registers
  always_comb begin
    mem_stall  = rd_go || state_q == WAIT;
    mem_err    = err;
    mem_rvalid = state_q == DONE;
    mem_din    = din_q;
    err_count  = errc_q;
    errc_d     = (err && mem_en && errc_q != 8'hFF) ? errc_q + 8'd1 : errc_q;
  end
  // word writes land at the edge, so a read issued next cycle sees them without bypass
  always_ff @(posedge clk) begin
    if (wr_go) ram_q[word] <= mem_dout;
  end
  // read data register; a one-cycle read uses the live address since nothing was captured yet
  always_ff @(posedge clk) begin
    if (rst) din_q <= 32'd0;
    else if (load) din_q <= ram_q[in_idle ? word : addr_q];
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench over LATENCY 1, 2 and 4 instances sharing one request bus
module tb_data_mem_responder;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, ren = 1'b0, wen = 1'b0;
  logic [31:0] addr = 32'd0, dout = 32'd0;
  logic [31:0] din1, din2, din4;
  logic rv1, rv2, rv4, st1, st2, st4, er1, er2, er4;
  logic [7:0] ec1, ec2, ec4;
  int checks = 0, failures = 0, ec_exp = 0;
  logic [31:0] exp_q[$];

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) d1 (.clk(clk), .rst(rst), .mem_en(en), .mem_ren(ren), .mem_wen(wen),
    .mem_addr(addr), .mem_dout(dout), .mem_din(din1), .mem_rvalid(rv1), .mem_stall(st1), .mem_err(er1), .err_count(ec1));
  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) d2 (.clk(clk), .rst(rst), .mem_en(en), .mem_ren(ren), .mem_wen(wen),
    .mem_addr(addr), .mem_dout(dout), .mem_din(din2), .mem_rvalid(rv2), .mem_stall(st2), .mem_err(er2), .err_count(ec2));
  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) d4 (.clk(clk), .rst(rst), .mem_en(en), .mem_ren(ren), .mem_wen(wen),
    .mem_addr(addr), .mem_dout(dout), .mem_din(din4), .mem_rvalid(rv4), .mem_stall(st4), .mem_err(er4), .err_count(ec4));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic rv_of(int l);
    return l == 1 ? rv1 : (l == 2 ? rv2 : rv4);
  endfunction
  function automatic logic st_of(int l);
    return l == 1 ? st1 : (l == 2 ? st2 : st4);
  endfunction
  function automatic logic [31:0] din_of(int l);
    return l == 1 ? din1 : (l == 2 ? din2 : din4);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #4;
  endtask
  task automatic idle_all;
    ren = 1'b0;
    wen = 1'b0;
    en  = 1'b1;
    repeat (10) step();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    en = 1'b1; ren = 1'b0; wen = 1'b1; addr = a; dout = d;
    settle();
    checks++;
    if ({er2, st2} !== 2'b00) begin
      failures++;
      $display("FAIL write_flags addr=%h err/stall=%b expected 00", a, {er2, st2});
    end
    step();
  endtask

  task automatic do_read(input int lat, input logic [31:0] a, input logic [31:0] d, input int hold);
    int n = 0;
    logic got = 1'b0;
    logic [31:0] e;
    wen = 1'b0; ren = 1'b1; addr = a; en = 1'b1;
    exp_q.push_back(d);
    settle();
    for (int i = 0; i < 20 && !got; i++) begin
      if (rv_of(lat)) got = 1'b1;
      else begin
        if (st_of(lat)) n++;
        step();
        settle();
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL read_timeout lat=%0d addr=%h rvalid never rose", lat, a);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (n !== lat) begin
        failures++;
        $display("FAIL stall_cycles lat=%0d got=%0d expected=%0d", lat, n, lat);
      end
      checks++;
      if (st_of(lat) !== 1'b0) begin
        failures++;
        $display("FAIL stall_in_done lat=%0d got=%b expected 0", lat, st_of(lat));
      end
      checks++;
      if (din_of(lat) !== e) begin
        failures++;
        $display("FAIL read_data lat=%0d addr=%h got=%h expected=%h", lat, a, din_of(lat), e);
      end
      if (hold > 0) en = 1'b0;
      for (int h = 0; h < hold; h++) begin
        step();
        settle();
        checks++;
        if (rv_of(lat) !== 1'b1 || din_of(lat) !== e) begin
          failures++;
          $display("FAIL hold_done cycle=%0d rvalid=%b din=%h expected 1/%h", h, rv_of(lat), din_of(lat), e);
        end
      end
      en = 1'b1;
      step();
      ren = 1'b0;
      settle();
      checks++;
      if ({rv_of(lat), st_of(lat)} !== 2'b00) begin
        failures++;
        $display("FAIL back_to_idle lat=%0d rvalid/stall=%b expected 00", lat, {rv_of(lat), st_of(lat)});
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ren = 1'b0; wen = 1'b0; en = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    settle();
    checks++;
    if (din2 !== 32'd0 || ec2 !== 8'd0) begin
      failures++;
      $display("FAIL reset_regs din=%h err_count=%0d expected 0/0", din2, ec2);
    end
    checks++;
    if ({rv1, rv2, rv4, st2, er2} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b expected 00000", {rv1, rv2, rv4, st2, er2});
    end
  endtask

  task automatic test_write_read;
    do_write(32'h10, 32'hDEADBEEF);
    do_read(2, 32'h10, 32'hDEADBEEF, 0);
    idle_all();
  endtask

  task automatic test_lat1;
    do_write(32'h24, 32'h12345678);
    do_read(1, 32'h24, 32'h12345678, 0);
    idle_all();
  endtask

  task automatic test_hold;
    do_read(2, 32'h10, 32'hDEADBEEF, 3);
    idle_all();
  endtask

  task automatic test_wen_ignored;
    logic got = 1'b0;
    logic [31:0] e;
    en = 1'b0; ren = 1'b1; wen = 1'b0; addr = 32'h24;
    exp_q.push_back(32'h12345678);
    step();
    wen = 1'b1; dout = 32'hFFFFFFFF;
    for (int i = 0; i < 10 && !got; i++) begin
      settle();
      checks++;
      if ({er1, er2, er4} !== 3'b000) begin
        failures++;
        $display("FAIL wen_busy_err cycle=%0d got=%b expected 000", i, {er1, er2, er4});
      end
      if (rv4) got = 1'b1;
      else step();
    end
    e = exp_q.pop_front();
    checks++;
    if (!got || din4 !== e) begin
      failures++;
      $display("FAIL wen_busy_read rvalid=%b din=%h expected 1/%h", got, din4, e);
    end
    en = 1'b1;
    step();
    ren = 1'b0; wen = 1'b0;
    idle_all();
    do_read(1, 32'h24, 32'h12345678, 0);
    idle_all();
  endtask

  task automatic test_illegal;
    logic [31:0] prev;
    logic [31:0] a_t [3] = '{32'h11, 32'h0001_0000, 32'h20};
    logic [1:0]  rw_t [3] = '{2'b10, 2'b01, 2'b11};
    do_write(32'h20, 32'hA5A5_0008);
    prev = din2;
    for (int k = 0; k < 3; k++) begin
      {ren, wen} = rw_t[k]; addr = a_t[k]; dout = 32'hBAD0BAD0; en = 1'b1;
      settle();
      checks++;
      if ({er2, st2} !== 2'b10 || ec2 !== 8'(ec_exp)) begin
        failures++;
        $display("FAIL illegal_%0d err/stall=%b count=%0d expected 10/%0d", k, {er2, st2}, ec2, ec_exp);
      end
      step();
      ec_exp++;
    end
    ren = 1'b0; wen = 1'b0;
    settle();
    checks++;
    if (ec2 !== 8'd3 || din2 !== prev) begin
      failures++;
      $display("FAIL illegal_after count=%0d din=%h expected 3/%h", ec2, din2, prev);
    end
    do_read(2, 32'h20, 32'hA5A5_0008, 0);
    idle_all();
  endtask

  task automatic test_reset_mid;
    ren = 1'b1; wen = 1'b0; addr = 32'h10; en = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; ren = 1'b0;
    ec_exp = 0;
    settle();
    checks++;
    if ({st4, rv4} !== 2'b00 || din4 !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid stall/rvalid=%b din=%h expected 00/0", {st4, rv4}, din4);
    end
    do_read(4, 32'h10, 32'hDEADBEEF, 0);
    idle_all();
  endtask

  task automatic test_saturation;
    ren = 1'b1; wen = 1'b0; addr = 32'h12; en = 1'b1;
    repeat (300) step();
    ren = 1'b0;
    settle();
    checks++;
    if ({ec1, ec2, ec4} !== {3{8'd255}}) begin
      failures++;
      $display("FAIL saturation counts=%0d/%0d/%0d expected 255", ec1, ec2, ec4);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_lat1();
    test_hold();
    test_wen_ignored();
    test_illegal();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Data-memory slave on the MEM-stage port of the 5-stage pipelined MIPS CPU.
- Accepts word read/write requests from the datapath (`mem_ren`, `mem_wen`, `mem_addr`, `mem_dout`) and returns read data on `mem_din`.
- Backed by a synchronous-read word RAM with configurable access latency. Drives `mem_stall` to the pipeline controller while a read is outstanding.
- Flags misaligned, out-of-range and conflicting requests.

## Interface
- `ADDR_WIDTH`, default 10: word-address width; RAM holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 2: read access cycles, legal range 1..8.
- `clk` in 1: main clock; all state changes on its rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `mem_en` in 1: MEM-stage enable; low means the pipeline is held.
- `mem_ren` in 1: read request.
- `mem_wen` in 1: write request.
- `mem_addr` in 32: byte address.
- `mem_dout` in 32: write data from the CPU.
- `mem_din` out 32: read data to the CPU.
- `mem_rvalid` out 1: `mem_din` holds the data of the current read.
- `mem_stall` out 1: hold the pipeline; the request must stay stable.
- `mem_err` out 1: current request is illegal and is ignored.
- `err_count` out 8: saturating count of illegal requests.

## Operation
- **Legal request:** `mem_addr[1:0]==0`, `mem_addr[31:ADDR_WIDTH+2]==0`, and not (`mem_ren` & `mem_wen`).
- **Illegal request:** any `mem_ren` or `mem_wen` in IDLE that fails the legal check.
  - `mem_err`=1 combinationally in that cycle.
  - No RAM access, no stall, no state change, `mem_din` unchanged.
  - `err_count` increments at the edge if `mem_en`=1; it saturates at 255.
- **States:** IDLE, WAIT, DONE.
- **IDLE:**
  - Legal write with `mem_en`=1: `RAM[mem_addr[ADDR_WIDTH+1:2]]` <= `mem_dout` at the edge. No stall. Stay in IDLE.
  - Legal read: capture the word address and set the latency counter to LATENCY-1. Go to WAIT if LATENCY>1, else DONE. The read is started even if `mem_en`=0.
- **WAIT:**
  - Counter decrements each cycle; at 1, go to DONE.
  - RAM data is registered into `mem_din` on the edge entering DONE.
- **DONE:**
  - `mem_rvalid`=1 and `mem_stall`=0.
  - If `mem_en`=1, go to IDLE; otherwise stay in DONE with `mem_din` held.
  - Request inputs are ignored in DONE, since they still show the completed read.
- **Stall:** `mem_stall` = (IDLE & legal `mem_ren`) | WAIT.
- **Write/read ordering:** a write at cycle t followed by a read of the same word at t+1 returns the written value; no bypass is needed because RAM writes complete at the edge.
- **Write ignored outside IDLE:** `mem_wen` in WAIT or DONE is ignored and does not raise `mem_err`.
- **Reset values:**
  - `mem_din`=0, `mem_rvalid`=0, `mem_stall`=0, `mem_err`=0, `err_count`=0, state=IDLE.
  - RAM contents are not reset.
  - Reset mid-read abandons the read; the next cycle is IDLE.

## Timing
- Read issued at cycle t, with `mem_en`=1 at completion:
  - `mem_stall`=1 in cycles t..t+LATENCY-1.
  - `mem_rvalid`=1 and `mem_din` valid in cycle t+LATENCY.
  - A new request is sampled in cycle t+LATENCY+1.
- Write: zero stall; the word is visible to a read issued the next cycle.
- `mem_stall` and `mem_err` are combinational from the inputs in IDLE. All other outputs are registered.
- `err_count` updates one edge after the illegal cycle.

## Test plan
- **Write then read back, LATENCY=2:**
  - Stimulus: write 0xDEADBEEF to address 0x10 at cycle 0, then read 0x10 at cycle 1.
  - Required: `mem_stall`=1 in cycles 1–2; `mem_rvalid`=1 and `mem_din`=0xDEADBEEF in cycle 3; IDLE in cycle 4.
- **LATENCY=1 read:**
  - Stimulus: read an address holding 0x12345678.
  - Required: one stall cycle; data on the next cycle.
- **Held pipeline in DONE:**
  - Stimulus: hold `mem_en`=0 for 3 cycles in DONE.
  - Required: `mem_din` and `mem_rvalid`=1 held for all 3; IDLE one cycle after `mem_en` rises.
- **Illegal requests:**
  - Stimulus: read 0x11; then write 0x0001_0000 with ADDR_WIDTH=10; then `mem_ren`=`mem_wen`=1 at 0x20.
  - Required: `mem_err`=1 each cycle, no stall, RAM[8] unchanged, `err_count`=3.
- **Reset mid-read:**
  - Stimulus: assert `rst` during WAIT with LATENCY=4.
  - Required: next cycle `mem_stall`=0, `mem_rvalid`=0, `mem_din`=0; a fresh read then completes normally.
- **`err_count` saturation:**
  - Stimulus: issue 300 misaligned requests.
  - Required: `err_count`=255.
